iq_deframer: RTL
================

// Module: iq_deframer
// PURPOSE
//  Consumes the two 1-bit DDR streams from ddr_in (rise/fall samples of AT86RF215 RXD).
//  Finds 32-bit I/Q word framing, holds lock, and emits sign-extended 13-bit I/Q
//  samples with a valid strobe.
//  Sits directly downstream of ddr_in and upstream of the baseband sample FIFO.
// PARAMETERS
//  OUT_W       16  output sample width, >= 13; I/Q are sign-extended to this width
//  LOCK_WORDS  4   consecutive good words needed in CHECK before LOCKED
//  LOSS_WORDS  3   consecutive bad words in LOCKED that drop lock back to HUNT
// PORTS
//  clk           in   1      DDR capture clock, same clock as ddr_in
//  rst           in   1      asynchronous, active-low reset (0 = reset)
//  din_a         in   1      rising-edge bit, ddr_in data_out_a[0]; earlier bit in serial order
//  din_b         in   1      falling-edge bit, ddr_in data_out_b[0]; later bit in serial order
//  err_clr       in   1      synchronous clear of sync_err_cnt
//  i_out         out  OUT_W  signed I sample
//  q_out         out  OUT_W  signed Q sample
//  iq_valid      out  1      1-clk pulse: i_out/q_out hold a new sample
//  locked        out  1      1 while state==LOCKED
//  sync_err_cnt  out  16     saturating count of bad words seen while LOCKED
// BEHAVIOUR
//  - Shift register sr[33:0] <= {sr[31:0], din_a, din_b} every clk (2 serial bits/clk).
//  - Word (MSB first): [31:30]=I_SYNC 2'b10, [29:17]=I, [16]=ctl,
//    [15:14]=Q_SYNC 2'b01, [13:1]=Q, [0]=ctl. ctl bits are ignored.
//  - Window w(p): p=0 -> sr[31:0]; p=1 -> sr[32:1].
//    good(p) := w[31:30]==2'b10 && w[15:14]==2'b01.
//  - State HUNT: each clk test good(0), then good(1).
//    On a match: phase<=p (p=0 has priority), bitcnt<=0, good_cnt<=1, go CHECK.
//  - bitcnt: 4-bit, increments every clk in CHECK/LOCKED, wraps 15->0.
//    A word is evaluated only in clks where bitcnt==15, i.e. every 16 clks.
//  - CHECK, eval clk:
//    - good(phase): good_cnt++. If the new count == LOCK_WORDS, go LOCKED and emit this word.
//    - bad: go HUNT. No error count.
//  - LOCKED, eval clk:
//    - good: emit the word, bad_cnt<=0.
//    - bad: no emit, bad_cnt++, sync_err_cnt++ (saturates at 16'hFFFF).
//      When the new bad_cnt == LOSS_WORDS: go HUNT, locked<=0.
//  - Emit: at the edge ending the eval clk, i_out<=sext(w[29:17]), q_out<=sext(w[13:1]),
//    iq_valid<=1 for exactly one clk.
//    - i_out/q_out hold their value between emits.
//    - Latency: outputs valid 1 clk after the clk in which the word's last bit enters sr.
//  - locked is a registered output. It rises on the same edge as the first iq_valid.
//  - err_clr has priority over an increment in the same clk; the result is 0.
//  - Reset (async assert, sync release):
//    - state=HUNT, sr=0, bitcnt=0, good_cnt=0, bad_cnt=0.
//    - Outputs: i_out=0, q_out=0, iq_valid=0, locked=0, sync_err_cnt=0.
//    - Reset mid-word discards the partial word. Relock needs the full LOCK_WORDS sequence.
//  - Bad words in LOCKED do not resync phase. Realignment happens only via HUNT.
// TESTING
//  1. Reset, then a continuous stream of word {10, I=13'd100, 0, 01, Q=-13'd100, 0}, phase 0
//     -> first iq_valid after LOCK_WORDS*16 clks; i_out=16'h0064, q_out=16'hFF9C;
//     then a pulse every 16 clks.
//  2. Same stream delayed by 1 serial bit (phase 1), I=-4096, Q=4095
//     -> lock; i_out=16'hF000, q_out=16'h0FFF.
//  3. Once locked, corrupt I_SYNC in 2 consecutive words
//     -> no iq_valid for those words, sync_err_cnt=2, locked stays 1;
//     next good word clears bad_cnt.
//  4. Once locked, corrupt LOSS_WORDS=3 consecutive words
//     -> locked=0 on the 3rd eval edge; relock after a further 4 good words.
//  5. In CHECK, a bad word after 2 good
//     -> back to HUNT, locked never rises, sync_err_cnt unchanged.
//  6. Assert rst=0 mid-word while locked
//     -> all outputs 0 immediately (async); after release, relock takes the full sequence.
//     Also: err_clr while an error increments in the same clk -> sync_err_cnt=0.

Source files
------------

// File: rtl/iq_deframer.sv
// iq_deframer: recovers 32-bit I/Q word framing from the two DDR bit streams
// of ddr_in. Hunts for the sync pattern, confirms it over several words, holds
// lock, and emits sign-extended 13-bit I/Q samples with a one-clock strobe.
module iq_deframer #(
    parameter int OUT_W      = 16,
    parameter int LOCK_WORDS = 4,
    parameter int LOSS_WORDS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_a,
    input  logic             din_b,
    input  logic             err_clr,
    output logic [OUT_W-1:0] i_out,
    output logic [OUT_W-1:0] q_out,
    output logic             iq_valid,
    output logic             locked,
    output logic [15:0]      sync_err_cnt
);

    localparam int GCW = $clog2(LOCK_WORDS + 1);
    localparam int BCW = $clog2(LOSS_WORDS + 1);
    // Counter value that, once incremented, reaches the threshold.
    localparam logic [GCW-1:0] GOOD_LAST = GCW'(LOCK_WORDS - 1);
    localparam logic [BCW-1:0] BAD_LAST  = BCW'(LOSS_WORDS - 1);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
    state_t state, state_nx;

    // Two serial bits per clock, din_a first. The top bit of a 34-bit shifter
    // never reaches either window, so only 33 bits are kept.
    logic [32:0]    sr;
    logic           phase;
    logic [3:0]     bitcnt;
    logic [GCW-1:0] good_cnt;
    logic [BCW-1:0] bad_cnt;

    logic        good0, good1, good_sel, eval;
    logic [12:0] i_fld, q_fld;
    logic        hunt_hit, hunt_ph, good_inc, bad_inc, bad_clr, emit;

    // Phase 0 window is sr[31:0], phase 1 window is sr[32:1].
    assign good0    = (sr[31:30] == 2'b10) && (sr[15:14] == 2'b01);
    assign good1    = (sr[32:31] == 2'b10) && (sr[16:15] == 2'b01);
    assign good_sel = phase ? good1 : good0;
    assign i_fld    = phase ? sr[30:18] : sr[29:17];
    assign q_fld    = phase ? sr[14:2]  : sr[13:1];
    // A full word has arrived once every 16 clocks after sync was found.
    assign eval     = (bitcnt == 4'hF);

    // Next-state and per-clock control decisions.
    always_comb begin
        state_nx = state;
        hunt_hit = 1'b0;
        hunt_ph  = 1'b0;
        good_inc = 1'b0;
        bad_inc  = 1'b0;
        bad_clr  = 1'b0;
        emit     = 1'b0;
        case (state)
            HUNT: begin
                // Phase 0 wins when both alignments look valid.
                if (good0) begin
                    hunt_hit = 1'b1;
                    state_nx = CHECK;
                end else if (good1) begin
                    hunt_hit = 1'b1;
                    hunt_ph  = 1'b1;
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                if (eval) begin
                    if (good_sel) begin
                        good_inc = 1'b1;
                        if (good_cnt == GOOD_LAST) begin
                            state_nx = LOCKED;
                            emit     = 1'b1;
                            bad_clr  = 1'b1;
                        end
                    end else begin
                        state_nx = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (eval) begin
                    if (good_sel) begin
                        emit    = 1'b1;
                        bad_clr = 1'b1;
                    end else begin
                        bad_inc = 1'b1;
                        if (bad_cnt == BAD_LAST) state_nx = HUNT;
                    end
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HUNT;
        else      state <= state_nx;
    end

    // Shifter, word phase and word/good/bad counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr       <= '0;
            phase    <= 1'b0;
            bitcnt   <= 4'd0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            sr <= {sr[30:0], din_a, din_b};
            if (hunt_hit) phase <= hunt_ph;
            // bitcnt sits at 0 while hunting so the first word boundary is
            // counted from the clock sync was found.
            if (state == HUNT) bitcnt <= 4'd0;
            else               bitcnt <= bitcnt + 4'd1;
            if (hunt_hit)      good_cnt <= GCW'(1);
            else if (good_inc) good_cnt <= good_cnt + GCW'(1);
            if (bad_clr || state != LOCKED) bad_cnt <= '0;
            else if (bad_inc)               bad_cnt <= bad_cnt + BCW'(1);
        end
    end

    // Registered sample outputs, strobe, lock flag and error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_out        <= '0;
            q_out        <= '0;
            iq_valid     <= 1'b0;
            locked       <= 1'b0;
            sync_err_cnt <= 16'd0;
        end else begin
            iq_valid <= emit;
            locked   <= (state_nx == LOCKED);
            if (emit) begin
                i_out <= OUT_W'($signed(i_fld));
                q_out <= OUT_W'($signed(q_fld));
            end
            // A clear wins over a same-clock increment.
            if (err_clr)
                sync_err_cnt <= 16'd0;
            else if (bad_inc && sync_err_cnt != 16'hFFFF)
                sync_err_cnt <= sync_err_cnt + 16'd1;
        end
    end

endmodule
